// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128 key schedule: latches the cipher key on start, then derives one
// round key per clock through a shared 4-byte SubWord and holds all eleven keys as static outputs.
module aes_key_expand_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] round0_key,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key,
    output logic         busy,
    output logic         keys_valid
);

    if (NR != 10) begin : g_nr_check
        $error("aes_key_expand_iter supports AES-128 only (NR must be 10)");
    end

    localparam logic [3:0] LAST = 4'(NR);

    // Forward S-box, byte 0x00 in the leftmost position.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state, state_next;
    logic [3:0]   count, count_next;
    logic         busy_next, valid_next, load, step;
    logic [127:0] rk [0:10];
    logic [127:0] prev_key, new_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        // SubWord(RotWord(w3)): the rotation is folded into the byte ordering.
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        prev_key = rk[count - 4'd1];
        new_key  = next_round_key(prev_key, rcon(count));
    end

    always_comb begin
        state_next = state;
        count_next = count;
        busy_next  = busy;
        valid_next = keys_valid;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = EXPAND;
                    count_next = 4'd1;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                    load       = 1'b1;
                end
            end
            EXPAND: begin
                step       = 1'b1;
                count_next = count + 4'd1;
                if (count == LAST) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 4'd0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                rk[i] <= '0;
            end
        end else begin
            state      <= state_next;
            count      <= count_next;
            busy       <= busy_next;
            keys_valid <= valid_next;
            if (load) begin
                rk[0] <= key;
            end
            if (step) begin
                rk[count] <= new_key;
            end
        end
    end

    assign round0_key  = rk[0];
    assign round1_key  = rk[1];
    assign round2_key  = rk[2];
    assign round3_key  = rk[3];
    assign round4_key  = rk[4];
    assign round5_key  = rk[5];
    assign round6_key  = rk[6];
    assign round7_key  = rk[7];
    assign round8_key  = rk[8];
    assign round9_key  = rk[9];
    assign round10_key = rk[10];

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Scoreboard bench for aes_key_expand_iter: stimulus queues expected key sets,
// a negedge monitor checks them (and the busy run length) when keys_valid rises.
module tb_aes_key_expand_iter;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [127:0] rko [0:10];
    logic         busy;
    logic         keys_valid;

    typedef struct packed {
        logic [10:0][127:0] keys;
        logic [10:0]        mask;
        logic [7:0]         busy_len;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [10:0][127:0] FIPS = {
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
        128'hac7766f319fadc2128d12941575c006e,
        128'head27321b58dbad2312bf5607f8d292f,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'h2b7e151628aed2a6abf7158809cf4f3c
    };

    localparam logic [10:0][127:0] ZERO = {
        128'hb4ef5bcb3e92e21123e951cf6f8f188e,
        {7{128'h0}},
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h62636363626363636263636362636363,
        128'h0
    };
    localparam logic [10:0] ZERO_MASK = 11'b100_0000_0111;

    aes_key_expand_iter #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .round0_key(rko[0]), .round1_key(rko[1]), .round2_key(rko[2]),
        .round3_key(rko[3]), .round4_key(rko[4]), .round5_key(rko[5]),
        .round6_key(rko[6]), .round7_key(rko[7]), .round8_key(rko[8]),
        .round9_key(rko[9]), .round10_key(rko[10]),
        .busy(busy), .keys_valid(keys_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (keys_valid) return;
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_valid: keys_valid never rose within 40 cycles");
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_valid"}, 128'(keys_valid), 128'd0);
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("%s_rk%0d", tag, i), rko[i], 128'd0);
        end
    endtask

    // Monitor: busy run length and key comparison on each keys_valid rising edge.
    initial begin : monitor
        int   run;
        int   last_len;
        logic prev_valid;
        exp_t e;
        run        = 0;
        last_len   = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                run++;
            end else begin
                if (run != 0) last_len = run;
                run = 0;
            end
            if (keys_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: keys_valid rose with no expectation queued");
                end else begin
                    e = q.pop_front();
                    for (int i = 0; i <= 10; i++) begin
                        if (e.mask[i]) check($sformatf("round%0d_key", i), rko[i], e.keys[i]);
                    end
                    check("busy_len", 128'(last_len), 128'(e.busy_len));
                end
            end
            prev_valid = keys_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        start = 1'b0;
        key   = '0;
        repeat (3) tick();
        check_cleared("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 key from IDLE
        q.push_back('{keys: FIPS, mask: 11'h7ff, busy_len: 8'd10});
        issue(FIPS[0]);
        check("accept_busy", 128'(busy), 128'd1);
        check("accept_valid", 128'(keys_valid), 128'd0);
        check("accept_rk0", rko[0], FIPS[0]);
        wait_valid();

        // Restart from DONE with the all-zero key
        q.push_back('{keys: ZERO, mask: ZERO_MASK, busy_len: 8'd10});
        issue(128'h0);
        check("restart_valid", 128'(keys_valid), 128'd0);
        check("restart_rk0", rko[0], 128'h0);
        check("restart_rk10_old", rko[10], FIPS[10]);
        wait_valid();

        // start pulsed mid-expansion must be ignored
        q.push_back('{keys: FIPS, mask: 11'h7ff, busy_len: 8'd10});
        issue(FIPS[0]);
        repeat (3) tick();
        issue(128'h0);
        check("ignored_rk0", rko[0], FIPS[0]);
        wait_valid();

        // Reset in the middle of an expansion
        issue(128'h0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_cleared("abort");
        q.push_back('{keys: FIPS, mask: 11'h7ff, busy_len: 8'd10});
        issue(FIPS[0]);
        wait_valid();

        // start coincident with reset: reset wins
        rst_n = 1'b0;
        issue(FIPS[0]);
        rst_n = 1'b1;
        check_cleared("rst_start");
        repeat (3) tick();
        check("rst_start_idle_busy", 128'(busy), 128'd0);
        check("rst_start_idle_rk0", rko[0], 128'h0);

        repeat (3) tick();
        check("queue_drained", 128'(q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
